ulpi_reg_sequencer: RTL and testbench
=====================================

# ulpi_reg_sequencer

ULPI PHY register-access controller. It sits beside the USB device link logic on the ULPI bus, clocked by the same 60 MHz clock that is driven out on `usb_clk`. It accepts single register read or write requests from the AHB-side control logic and sequences the ULPI TX CMD, data and STP phases. It yields the bus to the PHY whenever `dir` is high and to the packet engine whenever a packet is active, and it reports completion or failure through a response pulse.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255. Maximum cycles spent waiting for `nxt` or `dir` in any single wait state before the attempt is abandoned.
- `MAX_RETRY`, default 3. Number of re-attempts allowed after a PHY abort before an error response is returned.

Ports:
- `hclk`  in  1  ULPI/system clock (60 MHz).
- `reset`  in  1  Asynchronous, active-high reset.
- `req_valid`  in  1  Request present.
- `req_ready`  out  1  Request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = register write, 0 = register read.
- `req_addr`  in  6  ULPI immediate register address.
- `req_wdata`  in  8  Write data.
- `rsp_valid`  out  1  One-cycle completion pulse.
- `rsp_rdata`  out  8  Read data. Held until the next response.
- `rsp_err`  out  1  Qualifies `rsp_valid`. Indicates timeout or retries exhausted.
- `pkt_active`  in  1  Packet TX/RX engine owns the bus.
- `reg_own`  out  1  Sequencer is driving `ulpi_data_o`/`ulpi_stp`. The top-level mux selects the sequencer outputs when this is high.
- `ulpi_dir`  in  1  PHY bus direction.
- `ulpi_nxt`  in  1  PHY next.
- `ulpi_data_i`  in  8  Bus data from the IOBUF.
- `ulpi_data_o`  out  8  Bus data to the IOBUF.
- `ulpi_stp`  out  1  Stop.

## Operation
States: IDLE, CMD, WDATA, STP, RTURN, RDATA, REND, WAIT_BUS.

- **IDLE**
  - `req_ready = !ulpi_dir && !pkt_active`.
  - On accept: latch write/addr/wdata, clear the retry count and timeout counter, go to CMD.
- **CMD**
  - `ulpi_data_o = {req_write ? 2'b10 : 2'b11, addr}`.
  - If `ulpi_dir` is sampled high: abort, go to WAIT_BUS with retry+1.
  - Else if `nxt` is sampled high: a write goes to WDATA, a read goes to RTURN.
- **WDATA**
  - `ulpi_data_o = wdata`.
  - If `dir` is high: abort, go to WAIT_BUS.
  - Else if `nxt` is high: go to STP.
- **STP**
  - `ulpi_stp = 1`, `ulpi_data_o = 8'h00` for exactly one cycle.
  - Then pulse `rsp_valid` (`rsp_err = 0`) and go to IDLE.
- **RTURN**
  - `ulpi_data_o = 0`.
  - Wait for `dir` high (PHY turnaround), then go to RDATA.
- **RDATA**
  - If `dir && !nxt`: capture `ulpi_data_i` into `rsp_rdata`, go to REND.
  - If `dir && nxt`: the PHY preempted the read with an RX. Go to WAIT_BUS with retry+1.
  - If `dir` is low: abort, go to WAIT_BUS.
- **REND**
  - Wait for `dir` low, then pulse `rsp_valid` (`rsp_err = 0`) and go to IDLE.
- **WAIT_BUS**
  - Wait for `!ulpi_dir && !pkt_active`.
  - If retry ≤ `MAX_RETRY`, go to CMD (timeout counter cleared).
  - Otherwise pulse `rsp_valid` with `rsp_err = 1` and go to IDLE.
- **Timeout**
  - The counter counts cycles in CMD, WDATA, RTURN and REND and clears on every state change.
  - When it reaches `TIMEOUT_CYCLES`: pulse `rsp_valid` with `rsp_err = 1`.
  - If in WDATA, pass through STP for one cycle first so the PHY is left idle.
  - Then go to IDLE.
- **`reg_own`**
  - High in CMD, WDATA and STP, and in RTURN/RDATA/REND/WAIT_BUS only while `dir` is low.
  - Low in IDLE.
  - While `reg_own = 0`, `ulpi_data_o = 0` and `ulpi_stp = 0`.
- **`pkt_active`** is only checked in IDLE and WAIT_BUS. Once a command has started, the packet engine must wait on `reg_own`.

## Timing
- All outputs are registered except `req_ready` and `reg_own`, which are decoded from the state register and inputs.
- Reset values: state IDLE; `ulpi_data_o = 0`, `ulpi_stp = 0`, `rsp_valid = 0`, `rsp_err = 0`, `rsp_rdata = 0`, `reg_own = 0`. `req_ready = 0` while `reset` is high.
- Reset during an operation: the bus is released immediately, no response is issued, and the latched request is discarded.
- Write, best case with `nxt` high on the first eligible cycle:
  - accept at cycle 0;
  - TX CMD on cycle 1;
  - data on cycle 2;
  - STP on cycle 3;
  - `rsp_valid` on cycle 4.
- Read, best case:
  - TX CMD on cycle 1, with `nxt` in cycle 1;
  - turnaround cycle 2 (`dir` rises);
  - data captured at the end of cycle 3;
  - `dir` falls in cycle 4;
  - `rsp_valid` on cycle 5.
- `dir` and `nxt` are sampled on the rising edge of `hclk`.
- When `dir` and `nxt` rise in the same cycle, `dir` takes precedence (abort).
- `rsp_valid` is high for exactly one cycle per accepted request. A new request cannot be accepted on the same cycle as `rsp_valid`; the earliest accept is the following cycle.

## Test plan
1. Write addr 0x0A, data 0x55; PHY asserts `nxt` on cycles 1 and 2. Required: bus shows 0x8A, then 0x55, then 0x00 with `stp` = 1; `rsp_valid` on cycle 4 with `rsp_err` = 0.
2. Read addr 0x00; PHY returns 0x24 with a correct turnaround. Required: bus shows 0xC0; `rsp_rdata` = 0x24; `rsp_err` = 0; `reg_own` = 0 while `dir` = 1.
3. Write where `dir` rises during CMD twice, then the third attempt succeeds. Required: 0x8A is reissued after each `dir` fall; a single `rsp_valid` with `rsp_err` = 0.
4. Read where the PHY answers with `dir` = `nxt` = 1 on every attempt. Required: 4 attempts (initial plus 3 retries), then `rsp_valid` with `rsp_err` = 1; `rsp_rdata` unchanged.
5. `nxt` held low in CMD. Required: after `TIMEOUT_CYCLES` cycles, `rsp_valid` with `rsp_err` = 1; IDLE; `reg_own` = 0.
6. `pkt_active` = 1 at request time, and separately `reset` asserted during WDATA. Required: `req_ready` stays 0 until `pkt_active` falls; after reset, `ulpi_stp` = 0, `ulpi_data_o` = 0, and no `rsp_valid`.

Source files
------------

// File: rtl/ulpi_reg_sequencer.sv
// ULPI PHY register read/write sequencer: drives TX CMD, data and STP phases and
// yields the bus to the PHY (dir) or the packet engine (pkt_active).
module ulpi_reg_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic       hclk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  input  logic       pkt_active,
  output logic       reg_own,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_stp
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WDATA, S_STP, S_RTURN, S_RDATA, S_REND, S_WAIT_BUS
  } state_t;

  state_t           state_q, state_d;
  logic             write_q, write_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic [7:0]       data_q, data_d;
  logic             stp_q, stp_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             timeout_hit;

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      retry_q     <= '0;
      cnt_q       <= '0;
      to_q        <= 1'b0;
      data_q      <= '0;
      stp_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      data_q      <= data_d;
      stp_q       <= stp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end

  // A response cycle blocks acceptance so a new request starts the cycle after.
  assign req_ready   = (state_q == S_IDLE) && !ulpi_dir && !pkt_active && !rsp_valid_q && !reset;
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    retry_d     = retry_q;
    to_d        = to_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          retry_d = '0;
          to_d    = 1'b0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (ulpi_dir) begin
          retry_d = retry_q + RTY_W'(1);
          state_d = S_WAIT_BUS;
        end else if (ulpi_nxt) begin
          state_d = write_q ? S_WDATA : S_RTURN;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WDATA: begin
        if (ulpi_dir) begin
          retry_d = retry_q + RTY_W'(1);
          state_d = S_WAIT_BUS;
        end else if (ulpi_nxt) begin
          state_d = S_STP;
        end else if (timeout_hit) begin
          // Finish with STP so the PHY is not left mid-transmit.
          to_d    = 1'b1;
          state_d = S_STP;
        end
      end
      S_STP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = to_q;
        state_d     = S_IDLE;
      end
      S_RTURN: begin
        if (ulpi_dir) begin
          state_d = S_RDATA;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_RDATA: begin
        if (ulpi_dir && !ulpi_nxt) begin
          rdata_d = ulpi_data_i;
          state_d = S_REND;
        end else begin
          retry_d = retry_q + RTY_W'(1);
          state_d = S_WAIT_BUS;
        end
      end
      S_REND: begin
        if (!ulpi_dir) begin
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WAIT_BUS: begin
        if (!ulpi_dir && !pkt_active) begin
          if (retry_q <= RTY_MAX) begin
            state_d = S_CMD;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = '0;
    if ((state_d == state_q) && (state_q inside {S_CMD, S_WDATA, S_RTURN, S_REND}))
      cnt_d = cnt_q + CNT_W'(1);

    // Bus outputs are registered from the next state so they line up with it.
    data_d = 8'h00;
    if (state_d == S_CMD)
      data_d = {(write_d ? 2'b10 : 2'b11), addr_d};
    else if (state_d == S_WDATA)
      data_d = wdata_d;
    stp_d = (state_d == S_STP);
  end

  always_comb begin
    reg_own = 1'b0;
    case (state_q)
      S_CMD, S_WDATA, S_STP:                    reg_own = 1'b1;
      S_RTURN, S_RDATA, S_REND, S_WAIT_BUS:     reg_own = !ulpi_dir;
      default:                                  reg_own = 1'b0;
    endcase
  end

  assign ulpi_data_o = data_q;
  assign ulpi_stp    = stp_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rdata_q;
endmodule

// File: tb/tb_ulpi_reg_sequencer.sv
// Bench for ulpi_reg_sequencer: acts as the ULPI PHY and compares responses against
// a transaction-level model of attempts, errors and read data.
module tb_ulpi_reg_sequencer;
  localparam int TO = 255;
  localparam int MR = 3;

  logic       hclk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [5:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       pkt_active = 1'b0;
  logic       reg_own;
  logic       ulpi_dir = 1'b0;
  logic       ulpi_nxt = 1'b0;
  logic [7:0] ulpi_data_i = '0;
  logic [7:0] ulpi_data_o;
  logic       ulpi_stp;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rsp_seen = 0;
  int         rsp_exp = 0;
  logic [7:0] model_rdata = 8'h00;
  logic       prev_rsp = 1'b0;

  ulpi_reg_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .hclk(hclk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pkt_active(pkt_active), .reg_own(reg_own),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
    .ulpi_data_i(ulpi_data_i), .ulpi_data_o(ulpi_data_o), .ulpi_stp(ulpi_stp)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, failed=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge hclk);
  endtask

  // Bus-ownership invariants, every cycle out of reset.
  always @(negedge hclk) begin
    if (reset) begin
      prev_rsp = 1'b0;
    end else begin
      if (!reg_own) begin
        chk("released_bus_data", ulpi_data_o, 8'h00);
        chk("released_bus_stp", ulpi_stp, 1'b0);
      end
      if (rsp_valid) begin
        rsp_seen++;
        chk("rsp_single_cycle", prev_rsp, 1'b0);
        chk("ready_low_on_rsp", req_ready, 1'b0);
      end
      prev_rsp = rsp_valid;
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    #1;
    while (!req_ready && k < 50) begin
      tick();
      #1;
      k++;
    end
    chk("req_ready_wait", req_ready, 1'b1);
  endtask

  // PHY side of one request. mode: 0 random abort kind, 1 CMD abort, 2 RDATA preempt.
  task automatic run_txn(input bit wr, input logic [5:0] addr, input logic [7:0] wd,
                         input int aborts, input int mode, input logic [7:0] rbyte,
                         input bit best, input int pk, input logic [7:0] lit_cmd,
                         output bit got_rsp, output bit got_err, output logic [7:0] got_rdata,
                         output int attempts, output int lat);
    logic [7:0] cmd;
    int         acc, d;
    bit         ab, preempt;
    cmd = (lit_cmd != 8'h00) ? lit_cmd : {(wr ? 2'b10 : 2'b11), addr};
    got_rsp = 0; got_err = 0; got_rdata = 8'h00; attempts = 0; lat = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    pkt_active = (pk > 0);
    #1;
    if (rsp_valid) chk("no_accept_during_rsp", req_ready, 1'b0);
    for (int i = 0; i < pk; i++) begin
      tick();
      chk("ready_blocked_by_pkt", req_ready, 1'b0);
    end
    pkt_active = 1'b0;
    wait_ready();
    acc = cyc;
    tick();
    req_valid = 1'b0;
    for (int a = 0; a < 16; a++) begin
      attempts = a + 1;
      chk("cmd_byte", ulpi_data_o, cmd);
      chk("cmd_own", reg_own, 1'b1);
      chk("cmd_stp", ulpi_stp, 1'b0);
      ab = (a < aborts);
      preempt = ab && !wr && (mode == 2 || (mode == 0 && $urandom_range(0, 1) == 1));
      d = best ? 0 : $urandom_range(0, 2);
      for (int i = 0; i < d; i++) begin
        tick();
        chk("cmd_hold", ulpi_data_o, cmd);
      end
      if (ab && !preempt) begin
        ulpi_dir = 1'b1;
      end else begin
        ulpi_nxt = 1'b1;
        tick();
        ulpi_nxt = 1'b0;
        if (wr) begin
          chk("wdata_byte", ulpi_data_o, wd);
          d = best ? 0 : $urandom_range(0, 2);
          for (int i = 0; i < d; i++) begin
            tick();
            chk("wdata_hold", ulpi_data_o, wd);
          end
          ulpi_nxt = 1'b1;
          tick();
          ulpi_nxt = 1'b0;
          chk("stp_flag", ulpi_stp, 1'b1);
          chk("stp_data", ulpi_data_o, 8'h00);
          tick();
          got_rsp = rsp_valid; got_err = rsp_err; got_rdata = rsp_rdata; lat = cyc - acc;
          return;
        end
        chk("rturn_data", ulpi_data_o, 8'h00);
        chk("rturn_own", reg_own, 1'b1);
        d = best ? 0 : $urandom_range(0, 2);
        for (int i = 0; i < d; i++) begin
          tick();
          chk("rturn_hold", ulpi_data_o, 8'h00);
        end
        ulpi_dir = 1'b1;
        tick();
        chk("rdata_own", reg_own, 1'b0);
        if (preempt) begin
          ulpi_nxt = 1'b1;
          ulpi_data_i = 8'($urandom);
        end else begin
          ulpi_data_i = rbyte;
          tick();
          ulpi_data_i = 8'($urandom);
          chk("rend_own", reg_own, 1'b0);
          d = best ? 0 : $urandom_range(0, 2);
          repeat (d) tick();
          ulpi_dir = 1'b0;
          tick();
          got_rsp = rsp_valid; got_err = rsp_err; got_rdata = rsp_rdata; lat = cyc - acc;
          return;
        end
      end
      tick();
      ulpi_nxt = 1'b0;
      chk("yield_own", reg_own, 1'b0);
      chk("yield_data", ulpi_data_o, 8'h00);
      d = best ? 0 : $urandom_range(0, 2);
      repeat (d) tick();
      ulpi_dir = 1'b0;
      if (!best && $urandom_range(0, 3) == 0) begin
        pkt_active = 1'b1;
        tick();
        tick();
        pkt_active = 1'b0;
      end
      tick();
      if (rsp_valid) begin
        got_rsp = 1; got_err = rsp_err; got_rdata = rsp_rdata; lat = cyc - acc;
        return;
      end
    end
  endtask

  task automatic do_txn(input bit wr, input logic [5:0] addr, input logic [7:0] wd,
                        input int aborts, input int mode, input logic [7:0] rbyte,
                        input bit best, input int pk, input logic [7:0] lit_cmd,
                        input int exp_lat, input int exp_att_lit);
    bit         got_rsp, got_err, exp_err;
    logic [7:0] got_rdata;
    int         attempts, lat, exp_att;
    run_txn(wr, addr, wd, aborts, mode, rbyte, best, pk, lit_cmd,
            got_rsp, got_err, got_rdata, attempts, lat);
    rsp_exp++;
    exp_err = (aborts > MR);
    exp_att = exp_err ? MR + 1 : aborts + 1;
    if (!wr && !exp_err) model_rdata = rbyte;
    chk("rsp_present", got_rsp, 1'b1);
    chk("rsp_err", got_err, exp_err);
    chk("attempts", attempts, exp_att);
    chk("rsp_rdata", got_rdata, model_rdata);
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    if (exp_att_lit > 0) chk("attempts_literal", attempts, exp_att_lit);
  endtask

  task automatic to_txn(input bit in_wdata, input string name);
    int n;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h15; req_wdata = 8'hA5;
    wait_ready();
    tick();
    req_valid = 1'b0;
    chk("to_cmd_byte", ulpi_data_o, 8'h95);
    if (in_wdata) begin
      ulpi_nxt = 1'b1;
      tick();
      ulpi_nxt = 1'b0;
      chk("to_wdata_byte", ulpi_data_o, 8'hA5);
    end
    n = 0;
    while (!(in_wdata ? ulpi_stp : rsp_valid) && n < 400) begin
      tick();
      n++;
    end
    chk(name, n, TO);
    if (in_wdata) begin
      chk("to_stp_data", ulpi_data_o, 8'h00);
      tick();
    end
    rsp_exp++;
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_own", reg_own, 1'b0);
    chk("to_rdata", rsp_rdata, model_rdata);
    tick();
    chk("to_back_to_idle", req_ready, 1'b1);
  endtask

  initial begin
    bit         wr;
    logic [5:0] addr;
    logic [7:0] wd, rb;
    int         ab, pk;

    req_valid = 1'b1;
    tick();
    chk("rst_data", ulpi_data_o, 8'h00);
    chk("rst_stp", ulpi_stp, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_own", reg_own, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    req_valid = 1'b0;
    reset = 1'b0;
    tick();

    do_txn(1'b1, 6'h0A, 8'h55, 0, 1, 8'h00, 1'b1, 0, 8'h8A, 4, 1);
    do_txn(1'b0, 6'h00, 8'h00, 0, 1, 8'h24, 1'b1, 0, 8'hC0, 5, 1);
    do_txn(1'b1, 6'h0A, 8'h55, 2, 1, 8'h00, 1'b0, 0, 8'h8A, 0, 3);
    do_txn(1'b0, 6'h00, 8'h00, 9, 2, 8'h77, 1'b0, 0, 8'hC0, 0, 4);
    chk("preempt_keeps_rdata", rsp_rdata, 8'h24);

    to_txn(1'b0, "timeout_cmd_cycles");
    to_txn(1'b1, "timeout_wdata_cycles");

    do_txn(1'b1, 6'h2F, 8'hC3, 0, 1, 8'h00, 1'b0, 5, 8'hAF, 0, 1);

    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h04; req_wdata = 8'h3C;
    wait_ready();
    tick();
    req_valid = 1'b0;
    ulpi_nxt = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    chk("pre_reset_wdata", ulpi_data_o, 8'h3C);
    reset = 1'b1;
    #1;
    chk("reset_stp", ulpi_stp, 1'b0);
    chk("reset_data", ulpi_data_o, 8'h00);
    chk("reset_own", reg_own, 1'b0);
    chk("reset_ready", req_ready, 1'b0);
    chk("reset_rsp", rsp_valid, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    model_rdata = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_reset_no_rsp", rsp_valid, 1'b0);
    end
    chk("post_reset_rdata", rsp_rdata, 8'h00);

    for (int i = 0; i < 60; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 6'($urandom);
      wd   = 8'($urandom);
      rb   = 8'($urandom);
      ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
      pk   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_txn(wr, addr, wd, ab, 0, rb, 1'b0, pk, 8'h00, 0, 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    tick();
    chk("rsp_pulse_count", rsp_seen, rsp_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
